// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - Multi-entry register bank, one byte-masked write port, two registered read ports
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wbe,
    input  logic                  i_re_a,
    input  logic [ADDR_W-1:0]     i_raddr_a,
    output logic [DATA_W-1:0]     o_rdata_a,
    output logic                  o_rvalid_a,
    input  logic                  i_re_b,
    input  logic [ADDR_W-1:0]     i_raddr_b,
    output logic [DATA_W-1:0]     o_rdata_b,
    output logic                  o_rvalid_b
);

    localparam int             LP_BYTES = DATA_W / 8;
    localparam logic [ADDR_W:0] LP_NREGS = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              r_rvalid_a;
    logic              r_rvalid_b;

    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_merged;
    logic              w_waddr_ok;
    logic              w_wvalid;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < LP_BYTES; i++) begin
            w_wmask[8*i +: 8] = {8{i_wbe[i]}};
        end
    end

    // Post-write value of the addressed entry; also the bypass source.
    assign w_merged   = (r_mem[i_waddr] & ~w_wmask) | (i_wdata & w_wmask);
    assign w_waddr_ok = ({1'b0, i_waddr} < LP_NREGS) &&
                        !((ZERO_REG != 0) && (i_waddr == '0));
    assign w_wvalid   = i_we && w_waddr_ok;

    function automatic logic [DATA_W-1:0] f_select(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if ({1'b0, a} >= LP_NREGS) begin
            v = '0;
        end else if ((ZERO_REG != 0) && (a == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && i_we && (i_waddr == a)) begin
            v = w_merged;
        end else begin
            v = r_mem[a];
        end
        return v;
    endfunction

    always_comb begin
        w_sel_a = f_select(i_raddr_a);
        w_sel_b = f_select(i_raddr_b);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            if (w_wvalid) begin
                r_mem[i_waddr] <= w_merged;
            end
            r_rvalid_a <= i_re_a;
            r_rvalid_b <= i_re_b;
            if (i_re_a) begin
                r_rdata_a <= w_sel_a;
            end
            if (i_re_b) begin
                r_rdata_b <= w_sel_b;
            end
        end
    end

    assign o_rdata_a  = r_rdata_a;
    assign o_rdata_b  = r_rdata_b;
    assign o_rvalid_a = r_rvalid_a;
    assign o_rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - Scoreboard bench for reg_bank, two parameter sets driven in lockstep
module tb_reg_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wbe;
    logic          re_a, re_b;
    logic [AW-1:0] raddr_a, raddr_b;

    logic [DW-1:0] d0_rdata_a, d0_rdata_b, d1_rdata_a, d1_rdata_b;
    logic          d0_rvalid_a, d0_rvalid_b, d1_rvalid_a, d1_rvalid_b;

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
        .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(d0_rdata_a), .o_rvalid_a(d0_rvalid_a),
        .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(d0_rdata_b), .o_rvalid_b(d0_rvalid_b)
    );

    reg_bank #(.DATA_W(32), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
        .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(d1_rdata_a), .o_rvalid_a(d1_rvalid_a),
        .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(d1_rdata_b), .o_rvalid_b(d1_rvalid_b)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    // Reference contents and configuration of both instances
    logic [31:0] m [2][32];
    int          nregs [2] = '{32, 24};
    int          zr    [2] = '{1, 0};
    int          bp    [2] = '{1, 0};
    exp_t        q [4][$];
    logic [31:0] last [4];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] expect_read(input int d, input int a, input logic w,
                                                input int wa, input logic [31:0] wd,
                                                input logic [3:0] be);
        if (a >= nregs[d]) return 32'h0;
        if (zr[d] != 0 && a == 0) return 32'h0;
        if (bp[d] != 0 && w && wa == a) return merge(m[d][a], wd, be);
        return m[d][a];
    endfunction

    task automatic cycle(input logic rn, input logic w, input int wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic ea, input int ra,
                         input logic eb, input int rb);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = rn; we = w; waddr = wa[AW-1:0]; wdata = wd; wbe = be;
        re_a = ea; raddr_a = ra[AW-1:0]; re_b = eb; raddr_b = rb[AW-1:0];
        if (!rn) begin
            for (int d = 0; d < 2; d++) for (int i = 0; i < 32; i++) m[d][i] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                last[k] = 32'h0;
                e.v = 1'b0; e.d = 32'h0;
                q[k].push_back(e);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    int k;
                    k = d * 2 + p;
                    if ((p == 0) ? ea : eb) begin
                        last[k] = expect_read(d, (p == 0) ? ra : rb, w, wa, wd, be);
                        e.v = 1'b1;
                    end else begin
                        e.v = 1'b0;
                    end
                    e.d = last[k];
                    q[k].push_back(e);
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (w && wa < nregs[d] && !(zr[d] != 0 && wa == 0))
                    m[d][wa] = merge(m[d][wa], wd, be);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic rd(input int a, input int b);
        cycle(1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b1, b);
    endtask

    task automatic wr(input int wa, input logic [31:0] wd, input logic [3:0] be);
        cycle(1'b1, 1'b1, wa, wd, be, 1'b0, 0, 1'b0, 0);
    endtask

    // Monitor: one expectation per port per edge, checked on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0) begin
                exp_t e;
                logic        av;
                logic [31:0] ad;
                e = q[k].pop_front();
                case (k)
                    0: begin av = d0_rvalid_a; ad = d0_rdata_a; end
                    1: begin av = d0_rvalid_b; ad = d0_rdata_b; end
                    2: begin av = d1_rvalid_a; ad = d1_rdata_a; end
                    default: begin av = d1_rvalid_b; ad = d1_rdata_b; end
                endcase
                checks++;
                if (av !== e.v || ad !== e.d) begin
                    errors++;
                    $display("FAIL port%0d @%0t: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                             k, $time, av, ad, e.v, e.d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 32; i++) m[d][i] = 32'h0;
        for (int k = 0; k < 4; k++) last[k] = 32'h0;

        cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0);

        // Reset after random writes clears everything
        for (int i = 0; i < 10; i++) wr($urandom_range(31), $urandom, 4'hF);
        rd(3, 4);
        cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1, 3, 1'b1, 4);
        cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 32; i++) rd(i, 31 - i);

        // Basic write/read and byte mask
        wr(5, 32'hDEADBEEF, 4'hF);
        cycle(1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b1, 5, 1'b0, 0);
        wr(5, 32'h11223344, 4'b0101);
        rd(5, 5);

        // Bypass vs no bypass on address 7 which still holds 0
        cycle(1'b1, 1'b1, 7, 32'hA5A5A5A5, 4'hF, 1'b1, 7, 1'b1, 7);
        rd(7, 7);

        // Zero entry and out-of-range writes
        wr(0, 32'hFFFFFFFF, 4'hF);
        wr(30, 32'hFFFFFFFF, 4'hF);
        wr(6, 32'h12345678, 4'h0);
        rd(0, 30);
        for (int i = 0; i < 32; i++) rd(i, 31 - i);

        // Hold when re=0, then reset wins over a same-edge write
        rd(5, 7);
        idle();
        idle();
        cycle(1'b0, 1'b1, 9, 32'hCAFEF00D, 4'hF, 1'b1, 9, 1'b1, 5);
        rd(9, 5);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(63) != 0), ($urandom_range(2) != 0), $urandom_range(31),
                  $urandom, 4'($urandom_range(15)),
                  ($urandom_range(1) != 0), $urandom_range(31),
                  ($urandom_range(1) != 0), $urandom_range(31));
        end
        for (int i = 0; i < 32; i++) rd(i, i);
        idle();
        @(negedge clk);
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain port%0d: %0d entries left, expected 0", k, q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
